// File: rtl/nvr_mem_arbiter.sv
`default_nettype none
// nvr_mem_arbiter: arbitrates core fetch/data ports onto one NVR_TOP macro and sequences its CE/WE/RDY handshake.
// Rev 1.0
module nvr_mem_arbiter #(
  parameter int unsigned WE_SETUP = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        stall,
  output logic [31:0] mem_a,
  output logic [31:0] mem_din,
  output logic        mem_ce,
  output logic        mem_we,
  input  logic [31:0] mem_dout,
  input  logic        mem_rdy,
  output logic        err
);
  localparam logic [3:0] SETUP_LOAD = 4'(WE_SETUP - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        is_data_q, is_data_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [3:0]  setup_cnt_q, setup_cnt_d;
  logic [7:0]  acc_cnt_q, acc_cnt_d;
  logic        err_q, err_d;
  logic        rdy_prev_q;
  logic        rdy_rise;
  logic [31:0] cap_data;
  logic        unused_addr_lsbs;

  // Only a fresh RDY edge completes an access; a level left high from before is ignored.
  assign rdy_rise         = mem_rdy & ~rdy_prev_q;
  assign cap_data         = rdy_rise ? mem_dout : 32'h0;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_data_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      mem_a_q     <= '0;
      mem_din_q   <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      setup_cnt_q <= '0;
      acc_cnt_q   <= '0;
      err_q       <= 1'b0;
      rdy_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_data_q   <= is_data_d;
      is_wr_q     <= is_wr_d;
      mem_a_q     <= mem_a_d;
      mem_din_q   <= mem_din_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      setup_cnt_q <= setup_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      err_q       <= err_d;
      rdy_prev_q  <= mem_rdy;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_data_d   = is_data_q;
    is_wr_d     = is_wr_q;
    mem_a_d     = mem_a_q;
    mem_din_d   = mem_din_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    setup_cnt_d = setup_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        setup_cnt_d = SETUP_LOAD;
        acc_cnt_d   = '0;
        if (d_wr || d_rd) begin
          is_data_d = 1'b1;
          is_wr_d   = d_wr;
          mem_a_d   = {2'b00, d_addr[31:2]};
          mem_din_d = d_wdata;
          state_d   = d_wr ? S_SETUP : S_ACCESS;
        end else if (if_req) begin
          is_data_d = 1'b0;
          is_wr_d   = 1'b0;
          mem_a_d   = {2'b00, if_addr[31:2]};
          state_d   = S_ACCESS;
        end
      end
      S_SETUP: begin
        acc_cnt_d = '0;
        if (setup_cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          setup_cnt_d = setup_cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (rdy_rise || (acc_cnt_q == TO_LAST)) begin
          state_d = S_DONE;
          if (!rdy_rise) begin
            err_d = 1'b1;
          end
          if (!is_wr_q) begin
            if (is_data_q) begin
              d_rdata_d = cap_data;
            end else begin
              if_rdata_d = cap_data;
            end
          end
        end else begin
          acc_cnt_d = acc_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  assign mem_ce   = (state_q == S_ACCESS);
  assign mem_we   = (state_q == S_SETUP) || ((state_q == S_ACCESS) && is_wr_q);
  assign mem_a    = mem_a_q;
  assign mem_din  = mem_din_q;
  assign if_ack   = (state_q == S_DONE) && !is_data_q;
  assign d_ack    = (state_q == S_DONE) && is_data_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign err      = err_q;
  // Per-port pending so a fetch waiting behind a data access keeps the core stalled.
  assign stall    = (if_req & ~if_ack) | ((d_rd | d_wr) & ~d_ack);

endmodule
`default_nettype wire

// File: tb/tb_nvr_mem_arbiter.sv
`default_nettype none
// tb_nvr_mem_arbiter: randomized scoreboard bench with a behavioural macro and reference memory.
// Rev 1.0
module tb_nvr_mem_arbiter;
  localparam int WE_SETUP = 2;
  localparam int TIMEOUT  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        stall;
  logic [31:0] mem_a;
  logic [31:0] mem_din;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_dout;
  logic        mem_rdy;
  logic        err;

  always #5 clk = ~clk;

  nvr_mem_arbiter #(.WE_SETUP(WE_SETUP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .stall(stall),
    .mem_a(mem_a), .mem_din(mem_din), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_dout(mem_dout), .mem_rdy(mem_rdy), .err(err)
  );

  typedef struct {
    bit          is_data;
    bit          chk_data;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] macro_mem [0:255];
  logic [31:0] ref_mem   [0:255];
  int          checks = 0;
  int          failures = 0;
  int          rdy_delay = 0;
  bit          hang_mode = 1'b0;
  bit          stale_mode = 1'b0;
  logic        ref_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Macro model: answers CE with RDY after rdy_delay cycles; optional stale-RDY and hang behaviour.
  initial begin : macro_model
    mem_rdy  = 1'b0;
    mem_dout = '0;
    forever begin
      do begin
        @(negedge clk);
        mem_rdy = stale_mode;
        if (stale_mode) mem_dout = 32'hBAD0_BAD0;
      end while (mem_ce !== 1'b1);
      if (hang_mode) begin
        mem_rdy = 1'b0;
      end else if (stale_mode) begin
        @(negedge clk);
        mem_rdy = 1'b0;
        repeat (2) @(negedge clk);
        mem_dout = macro_mem[mem_a[7:0]];
        mem_rdy  = 1'b1;
      end else begin
        repeat (rdy_delay) @(negedge clk);
        if (mem_we === 1'b1) begin
          macro_mem[mem_a[7:0]] = mem_din;
          mem_dout = $urandom;
        end else begin
          mem_dout = macro_mem[mem_a[7:0]];
        end
        mem_rdy = 1'b1;
      end
      while (mem_ce === 1'b1) @(negedge clk);
      mem_rdy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && (if_ack === 1'b1 || d_ack === 1'b1)) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack if_ack=%b d_ack=%b required=no ack (t=%0t)", if_ack, d_ack, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("ack_port", {30'd0, if_ack, d_ack}, mon_e.is_data ? 32'd1 : 32'd2);
        if (mon_e.chk_data) check("rdata", mon_e.is_data ? d_rdata : if_rdata, mon_e.data);
        check("err_at_ack", {31'd0, err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic wait_ack(input bit scramble, output int ce_c, output int su_c, output int cewe_c,
                          output logic [31:0] a0, output logic [31:0] d0);
    int n;
    ce_c = 0; su_c = 0; cewe_c = 0; n = 0;
    @(negedge clk);
    a0 = mem_a;
    d0 = mem_din;
    while (if_ack !== 1'b1 && d_ack !== 1'b1) begin
      check("stall_pending", {31'd0, stall}, 32'd1);
      if (mem_ce === 1'b1) begin
        ce_c++;
        if (mem_we === 1'b1) cewe_c++;
      end else if (mem_we === 1'b1) begin
        su_c++;
      end
      if (scramble && n == 0) begin
        if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      end
      n++;
      if (n > 64) begin
        checks++;
        failures++;
        $display("FAIL ack_wait actual=no ack after %0d cycles required=ack", n);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input bit is_data, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit scramble);
    exp_t        e;
    int          ce_c, su_c, cewe_c, exp_ce;
    logic [31:0] a0, d0;
    if (hang_mode) ref_err = 1'b1;
    e.is_data  = is_data;
    e.chk_data = !(is_data && wr);
    e.data     = hang_mode ? 32'h0 : ref_mem[addr[9:2]];
    e.err      = ref_err;
    sb_q.push_back(e);
    exp_ce = hang_mode ? TIMEOUT : (stale_mode ? 4 : rdy_delay + 1);
    if (is_data) begin
      d_addr = addr; d_wdata = wdata; d_wr = wr; d_rd = ~wr;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    wait_ack(scramble, ce_c, su_c, cewe_c, a0, d0);
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    check("mem_a_at_grant", a0, {2'b00, addr[31:2]});
    if (is_data && wr) begin
      check("mem_din_at_grant", d0, wdata);
      check("we_setup_cycles", su_c, WE_SETUP);
      check("we_held_with_ce", cewe_c, ce_c);
    end else begin
      check("we_setup_cycles", su_c, 0);
      check("we_low_on_read", cewe_c, 0);
    end
    check("ce_cycles", ce_c, exp_ce);
    check("ce_we_low_at_ack", {30'd0, mem_ce, mem_we}, 32'd0);
    if (is_data && wr && !hang_mode) ref_mem[addr[9:2]] = wdata;
    @(negedge clk);
    check("stall_low_after_ack", {31'd0, stall}, 32'd0);
  endtask

  task automatic random_burst(input int n);
    for (int i = 0; i < n; i++) begin
      bit          isd, wr;
      logic [31:0] a;
      isd = 1'($urandom_range(0, 1));
      wr  = isd && ($urandom_range(0, 2) == 0);
      a   = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      rdy_delay = $urandom_range(0, 4);
      issue(isd, wr, a, $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin : stimulus
    exp_t        e;
    int          c1, s1, w1;
    logic [31:0] a1, x1;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      macro_mem[i] = v;
      ref_mem[i]   = v;
    end
    macro_mem[8'h16] = 32'h0000_0013;
    ref_mem[8'h16]   = 32'h0000_0013;
    #1 rst = 1'b1;
    #1;
    check("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    rdy_delay = 3;
    issue(1'b0, 1'b0, 32'h58, 32'h0, 1'b0);
    rdy_delay = 0;
    issue(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    rdy_delay = 2;
    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check("if_rdata_held", if_rdata, 32'h0000_0013);

    // Both ports on the same edge: data first, one idle cycle, then fetch.
    rdy_delay = 1;
    e.is_data = 1'b1; e.chk_data = 1'b1; e.data = ref_mem[8'h21]; e.err = ref_err; sb_q.push_back(e);
    e.is_data = 1'b0; e.chk_data = 1'b1; e.data = ref_mem[8'h30]; e.err = ref_err; sb_q.push_back(e);
    d_addr = 32'h84; d_rd = 1'b1; if_addr = 32'hC0; if_req = 1'b1;
    wait_ack(1'b0, c1, s1, w1, a1, x1);
    check("contention_data_first", {31'd0, d_ack}, 32'd1);
    check("contention_stall_at_d_ack", {31'd0, stall}, 32'd1);
    check("contention_data_addr", a1, 32'h21);
    d_rd = 1'b0;
    @(negedge clk);
    check("contention_gap_stall", {31'd0, stall}, 32'd1);
    check("contention_gap_ce", {31'd0, mem_ce}, 32'd0);
    wait_ack(1'b0, c1, s1, w1, a1, x1);
    check("contention_fetch_second", {31'd0, if_ack}, 32'd1);
    check("contention_stall_at_if_ack", {31'd0, stall}, 32'd0);
    check("contention_fetch_addr", a1, 32'h30);
    check("contention_fetch_ce_cycles", c1, 2);
    if_req = 1'b0;
    @(negedge clk);

    stale_mode = 1'b1;
    repeat (2) @(negedge clk);
    issue(1'b0, 1'b0, 32'h1A4, 32'h0, 1'b0);
    stale_mode = 1'b0;
    repeat (2) @(negedge clk);

    random_burst(20);

    hang_mode = 1'b1;
    issue(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
    hang_mode = 1'b0;
    check("err_sticky", {31'd0, err}, 32'd1);
    random_burst(4);
    check("err_still_sticky", {31'd0, err}, 32'd1);

    // Async reset in the middle of an access: strobes drop at once, no ack follows.
    rdy_delay = 5;
    if_addr = 32'h40; if_req = 1'b1;
    @(negedge clk);
    check("ce_before_rst", {31'd0, mem_ce}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ce", {31'd0, mem_ce}, 32'd0);
    check("rst_mid_we", {31'd0, mem_we}, 32'd0);
    check("rst_mid_err", {31'd0, err}, 32'd0);
    ref_err = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    rdy_delay = 2;
    issue(1'b0, 1'b0, 32'h44, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
